// File: rtl/cycle_watchdog.sv
// cycle_watchdog: programmable cycle-limit counter for bench timeouts,
// in-RTL watchdogs and periodic tick generation.
//
// Ports:
//   clk          rising-edge clock
//   clk_en       clock enable; state holds while low (reset and tick clear excepted)
//   sync_rst     synchronous active-high reset
//   start_i      latch limit/mode, clear count and expiry counter, enter RUN
//   stop_i       abort to IDLE (highest priority)
//   kick_i       clear count while running
//   pause_i      level; hold count while running
//   mode_i       0 = one-shot, 1 = periodic (sampled on start)
//   limit_i      terminal count (sampled on start)
//   count_o      current count
//   busy_o       high in RUN
//   expired_o    high in EXPIRED
//   tick_o       one-clk pulse after each limit hit
//   expire_cnt_o saturating count of limit hits since reset/start
module cycle_watchdog #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 clk_en,
  input  logic                 sync_rst,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 kick_i,
  input  logic                 pause_i,
  input  logic                 mode_i,
  input  logic [WIDTH-1:0]     limit_i,
  output logic [WIDTH-1:0]     count_o,
  output logic                 busy_o,
  output logic                 expired_o,
  output logic                 tick_o,
  output logic [CNT_WIDTH-1:0] expire_cnt_o
);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     count, count_nxt;
  logic [WIDTH-1:0]     limit_q, limit_nxt;
  logic                 mode_q, mode_nxt;
  logic                 tick_nxt;
  logic [CNT_WIDTH-1:0] exp_cnt, exp_nxt;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    limit_nxt = limit_q;
    mode_nxt  = mode_q;
    exp_nxt   = exp_cnt;
    tick_nxt  = 1'b0;
    if (stop_i) begin
      state_nxt = IDLE;
    end else if (start_i) begin
      state_nxt = RUN;
      limit_nxt = limit_i;
      mode_nxt  = mode_i;
      count_nxt = '0;
      exp_nxt   = '0;
    end else if (state == RUN) begin
      if (kick_i) begin
        count_nxt = '0;
      end else if (!pause_i) begin
        if (count == limit_q) begin
          tick_nxt = 1'b1;
          if (exp_cnt != '1) exp_nxt = exp_cnt + CNT_WIDTH'(1);
          // One-shot parks with count held at the limit.
          if (mode_q) count_nxt = '0;
          else        state_nxt = EXPIRED;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state   <= IDLE;
      count   <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
      tick_o  <= 1'b0;
      exp_cnt <= '0;
    end else begin
      // Tick clears on every edge so the pulse is one clk wide even when gated.
      tick_o <= 1'b0;
      if (clk_en) begin
        state   <= state_nxt;
        count   <= count_nxt;
        limit_q <= limit_nxt;
        mode_q  <= mode_nxt;
        exp_cnt <= exp_nxt;
        tick_o  <= tick_nxt;
      end
    end
  end

  assign count_o      = count;
  assign busy_o       = (state == RUN);
  assign expired_o    = (state == EXPIRED);
  assign expire_cnt_o = exp_cnt;

endmodule

// File: tb/tb_cycle_watchdog.sv
// Self-checking bench for cycle_watchdog: directed scenarios followed by a
// randomized phase, all compared against a behavioural model in the bench.
// A second instance with CNT_WIDTH=2 exercises expiry counter saturation.
module tb_cycle_watchdog;

  logic        clk = 1'b0;
  logic        clk_en, sync_rst, start, stop, kick, pause, mode;
  logic [31:0] limit;
  logic [31:0] count_o;
  logic        busy_o, expired_o, tick_o;
  logic [7:0]  exp_o;
  logic [7:0]  count2_o;
  logic        busy2_o, expired2_o, tick2_o;
  logic [1:0]  exp2_o;

  always #5 clk = ~clk;

  cycle_watchdog #(.WIDTH(32), .CNT_WIDTH(8)) dut (
    .clk(clk), .clk_en(clk_en), .sync_rst(sync_rst), .start_i(start),
    .stop_i(stop), .kick_i(kick), .pause_i(pause), .mode_i(mode),
    .limit_i(limit), .count_o(count_o), .busy_o(busy_o),
    .expired_o(expired_o), .tick_o(tick_o), .expire_cnt_o(exp_o)
  );

  cycle_watchdog #(.WIDTH(8), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .clk_en(clk_en), .sync_rst(sync_rst), .start_i(start),
    .stop_i(stop), .kick_i(kick), .pause_i(pause), .mode_i(mode),
    .limit_i(limit[7:0]), .count_o(count2_o), .busy_o(busy2_o),
    .expired_o(expired2_o), .tick_o(tick2_o), .expire_cnt_o(exp2_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: "running"/"done" flags plus plain integer counters.
  bit m_run, m_done, m_per, m_tick;
  int m_count, m_limit, m_hits;

  // Scenario bookkeeping taken from DUT observations.
  int edge_n, en_edges, first_tick, first_tick_en, ticks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_marks();
    edge_n = 0; en_edges = 0; first_tick = -1; first_tick_en = -1; ticks = 0;
  endtask

  task automatic model_edge(input bit rst, en, st, sp, kk, pz, md, input int lim);
    if (rst) begin
      m_run = 0; m_done = 0; m_per = 0; m_tick = 0;
      m_count = 0; m_limit = 0; m_hits = 0;
    end else begin
      m_tick = 0;
      if (en) begin
        if (sp) begin
          m_run = 0; m_done = 0;
        end else if (st) begin
          m_run = 1; m_done = 0; m_limit = lim; m_per = md;
          m_count = 0; m_hits = 0;
        end else if (m_run) begin
          if (kk) m_count = 0;
          else if (!pz) begin
            if (m_count == m_limit) begin
              m_tick = 1; m_hits++;
              if (m_per) m_count = 0;
              else begin m_run = 0; m_done = 1; end
            end else m_count++;
          end
        end
      end
    end
  endtask

  task automatic step(input bit rst, en, st, sp, kk, pz, md, input int lim);
    sync_rst = rst; clk_en = en; start = st; stop = sp;
    kick = kk; pause = pz; mode = md; limit = lim;
    @(posedge clk);
    model_edge(rst, en, st, sp, kk, pz, md, lim);
    #1;
    chk("count",    count_o,              32'(m_count));
    chk("busy",     32'(busy_o),          32'(m_run));
    chk("expired",  32'(expired_o),       32'(m_done));
    chk("tick",     32'(tick_o),          32'(m_tick));
    chk("exp_cnt",  32'(exp_o),           32'(m_hits > 255 ? 255 : m_hits));
    chk("count2",   32'(count2_o),        32'(m_count));
    chk("tick2",    32'(tick2_o),         32'(m_tick));
    chk("exp_cnt2", 32'(exp2_o),          32'(m_hits > 3 ? 3 : m_hits));
    edge_n++;
    if (en) en_edges++;
    if (tick_o) begin
      ticks++;
      if (first_tick < 0) begin first_tick = edge_n; first_tick_en = en_edges; end
    end
  endtask

  task automatic idle_step(input bit en);
    step(0, en, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_count", count_o, 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_exp", 32'(exp_o), 0);

    // One-shot, limit 5: hit on 6th edge after start, tick once
    step(0, 1, 1, 0, 0, 0, 0, 5);
    clear_marks();
    for (int i = 0; i < 10; i++) idle_step(1);
    chk("os_tick_edge", 32'(first_tick), 6);
    chk("os_ticks", 32'(ticks), 1);
    chk("os_expired", 32'(expired_o), 1);
    chk("os_count", count_o, 5);
    chk("os_expcnt", 32'(exp_o), 1);
    chk("os_busy", 32'(busy_o), 0);

    // Periodic, limit 3, 20 cycles
    step(0, 1, 1, 0, 0, 0, 1, 3);
    clear_marks();
    for (int i = 0; i < 20; i++) begin
      idle_step(1);
      chk("per_busy", 32'(busy_o), 1);
    end
    chk("per_ticks", 32'(ticks), 5);
    chk("per_expcnt", 32'(exp_o), 5);

    // One-shot limit 10 with pause at 3 (4 cycles) and kick at 7
    step(0, 1, 1, 0, 0, 0, 0, 10);
    clear_marks();
    for (int i = 0; i < 3; i++) idle_step(1);
    chk("pk_at3", count_o, 3);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 1, 0, 0);
    chk("pk_paused", count_o, 3);
    for (int i = 0; i < 4; i++) idle_step(1);
    chk("pk_at7", count_o, 7);
    step(0, 1, 0, 0, 1, 0, 0, 0);
    chk("pk_kicked", count_o, 0);
    for (int i = 0; i < 15; i++) idle_step(1);
    chk("pk_tick_edge", 32'(first_tick), 23);
    chk("pk_ticks", 32'(ticks), 1);

    // Limit 4 with clk_en alternating: hit on 5th enabled edge, 1-cycle tick
    step(0, 1, 1, 0, 0, 0, 0, 4);
    clear_marks();
    for (int i = 0; i < 14; i++) idle_step(i[0]);
    chk("en_tick_en_edge", 32'(first_tick_en), 5);
    chk("en_ticks", 32'(ticks), 1);
    chk("en_count", count_o, 4);

    // Reset mid-run (with clk_en low), then start+stop together
    step(0, 1, 1, 0, 0, 0, 0, 8);
    for (int i = 0; i < 6; i++) idle_step(1);
    chk("rr_at6", count_o, 6);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rr_count", count_o, 0);
    chk("rr_busy", 32'(busy_o), 0);
    step(0, 1, 1, 1, 0, 0, 1, 3);
    chk("ss_busy", 32'(busy_o), 0);
    chk("ss_tick", 32'(tick_o), 0);
    chk("ss_expired", 32'(expired_o), 0);

    // Limit 0 periodic: tick every cycle, narrow counter saturates at 3
    step(0, 1, 1, 0, 0, 0, 1, 0);
    clear_marks();
    for (int i = 0; i < 10; i++) idle_step(1);
    chk("l0_ticks", 32'(ticks), 10);
    chk("l0_exp2", 32'(exp2_o), 3);
    chk("l0_exp", 32'(exp_o), 10);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 14) == 0),
           ($urandom_range(0, 4) == 0),
           $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 12)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
